jtag_dtm_tap: RTL
=================

// Module: jtag_dtm_tap
// PURPOSE
//  - Target-side JTAG TAP and RISC-V debug transport module (DTM, spec 0.13) inside the soc.
//  - Responder to the external bit-bang JTAG driver (tck/tms/tdi in, tdo out).
//  - Oversamples the JTAG pins on the system clock and runs the IEEE 1149.1 TAP state machine.
//  - Converts DMI DR scans into DMI request/response handshakes toward the debug module.
// PARAMETERS
//  IDCODE     32'h1000_0001  Value captured into the IDCODE DR.
//  ABITS      7              DMI address width; DMI DR width is ABITS+34.
//  IDLE_HINT  3'd1           Value reported in the dtmcs.idle field.
// PORTS
//  clk            in   1        System clock; all state is clocked on its rising edge.
//  rst            in   1        Synchronous, active-high reset.
//  tck            in   1        JTAG clock, asynchronous to clk.
//  tms            in   1        JTAG mode select, asynchronous to clk.
//  tdi            in   1        JTAG data in, asynchronous to clk.
//  trst           in   1        JTAG reset, active low. Port exists only with JTAG_TRST_EN.
//  tdo            out  1        JTAG data out.
//  tdo_en         out  1        High while in Shift-IR or Shift-DR.
//  dmi_req_valid  out  1        DMI request valid.
//  dmi_req_ready  in   1        DMI request accepted by the debug module.
//  dmi_req_addr   out  ABITS    DMI request address.
//  dmi_req_data   out  32       DMI write data.
//  dmi_req_op     out  2        DMI op: 1 = read, 2 = write.
//  dmi_resp_valid in   1        DMI response valid. Always accepted; there is no ready.
//  dmi_resp_data  in   32       DMI response data.
//  dmi_resp_op    in   2        DMI response status: 0 = ok, 2 = failed, 3 = busy.
// BEHAVIOUR
//  - Sampling: tck, tms, tdi (and trst) each pass through a 2-FF synchronizer.
//    - A tck rise is one clk in which the synced tck is 1 and the previous synced tck was 0. A tck fall is the inverse.
//    - Required tck high and low time is at least 3 clk each.
//  - TAP FSM: the 16 standard 1149.1 states, advanced using synced tms on each tck rise.
//    - Five tck rises with tms=1 reach Test-Logic-Reset (TLR) from any state.
//    - In TLR, IR is forced to 5'h01.
//  - IR: 5 bits, shifted LSB first.
//    - Capture-IR loads 5'b00001.
//    - Update-IR latches the shifted value.
//    - IR decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI. Every other value selects BYPASS (1 bit, captures 0).
//  - DTMCS capture value: {14'b0, 2'b00, 1'b0, IDLE_HINT, dmistat[1:0], ABITS[5:0], 4'd1}.
//    - Update-DR with bit16 set (dmireset) clears dmistat.
//    - Update-DR with bit17 set (dmihardreset) clears dmistat and abandons any outstanding request: dmi_req_valid drops next clk and the next response is discarded.
//  - DMI DR layout is {addr, data[31:0], op[1:0]}, shifted LSB first.
//    - Capture-DR loads {last_addr, last_rdata, dmistat}.
//    - If a request is outstanding at capture, the captured op is 3 and dmistat latches 3 (sticky).
//  - DMI Update-DR:
//    - op 1 or 2, dmistat==0, nothing outstanding: drive req addr/data/op and assert dmi_req_valid on the next clk. Hold all req outputs stable until the clk in which dmi_req_ready=1; valid deasserts after that clk.
//    - op 1 or 2 while outstanding: dmistat := 3 and the request is dropped.
//    - op 1 or 2 while dmistat!=0: the request is dropped silently.
//    - op 0 or 3: no action.
//    - An update and a response arriving in the same clk: the response is processed first, so the update sees "not outstanding".
//  - Outstanding spans from issue until dmi_resp_valid.
//    - On response: last_rdata := dmi_resp_data.
//    - resp_op 2 sets dmistat to 2; resp_op 3 sets it to 3. dmistat is never overwritten once nonzero.
//  - Shift: on a tck rise in Shift-xR the selected register shifts right with tdi entering the MSB.
//  - tdo: updated on a tck fall, equal to the LSB of the active shift register. tdo_en is registered on the same fall.
//  - Reset values: tdo=0, tdo_en=0, dmi_req_valid=0, dmi_req_addr/data/op=0, FSM=TLR, IR=0x01, dmistat=0, last_addr=0, last_rdata=0.
//    - rst mid-scan or mid-request returns everything to these values; a response in flight after rst is ignored.
// CONFIGURATION
//  JTAG_TRST_EN defined:
//    - trst port present.
//    - Synced trst=0 forces FSM=TLR and IR=0x01 within 3 clk.
//    - DMI state and the outstanding request are not affected.
//  JTAG_TRST_EN undefined:
//    - No trst port.
//    - TAP reset only via rst or tms=1 for 5 tck.
// TESTING
//  - rst; 5 tck with tms=1, go to Shift-DR, 32 tck -> tdo bits LSB first = 32'h1000_0001; tdo_en=1 only while shifting.
//  - IR=0x10, scan 32 zero bits -> captured 32'h0000_1071 (ABITS=7, idle=1, version 1).
//  - IR=0x11, scan {7'h11, 32'hDEAD_BEEF, 2'd2} -> one req: addr 0x11, data DEADBEEF, op 2.
//    - Hold ready=0 for 10 clk: valid and payload stay stable. Then ready=1: valid falls the next clk.
//  - Read op issued, no response yet, rescan DMI -> captured op=3.
//    - A further write scan issues no request.
//    - Response arrives; a dtmcs scan with bit16=1 clears dmistat; a next DMI scan captures op=0.
//  - Read op, response data 32'h1234_5678 resp_op 0 -> next DMI capture shows data 12345678, op 0.
//    - Repeat with resp_op 2 -> captured op=2, sticky until dmireset.
//  - JTAG_TRST_EN: mid Shift-DR drive trst=0 -> FSM in TLR and IR=0x01 within 3 clk; rst assert mid-request -> dmi_req_valid=0 the next clk.

Source files
------------

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP plus RISC-V debug transport (IDCODE/DTMCS/DMI) with pins oversampled on clk.
// Defining JTAG_TRST_EN adds an active-low trst input that resets only the TAP and IR.
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter int unsigned ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
`ifdef JTAG_TRST_EN
  input  logic             trst,
`endif
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);

  localparam int unsigned DRW     = ABITS + 34;
  localparam logic [4:0]  IR_IDC  = 5'h01;
  localparam logic [4:0]  IR_DTM  = 5'h10;
  localparam logic [4:0]  IR_DMI  = 5'h11;
  localparam logic [5:0]  ABITS_F = 6'(ABITS);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     tap_next = m ? TLR    : RTI;
      RTI:     tap_next = m ? SEL_DR : RTI;
      SEL_DR:  tap_next = m ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = m ? EX1_DR : SH_DR;
      SH_DR:   tap_next = m ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = m ? UPD_DR : PA_DR;
      PA_DR:   tap_next = m ? EX2_DR : PA_DR;
      EX2_DR:  tap_next = m ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = m ? SEL_DR : RTI;
      SEL_IR:  tap_next = m ? TLR    : CAP_IR;
      CAP_IR:  tap_next = m ? EX1_IR : SH_IR;
      SH_IR:   tap_next = m ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = m ? UPD_IR : PA_IR;
      PA_IR:   tap_next = m ? EX2_IR : PA_IR;
      EX2_IR:  tap_next = m ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = m ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

  tap_e             tap_q;
  logic [2:0]       tck_sync_q;
  logic [1:0]       tms_sync_q, tdi_sync_q;
  logic             tck_rise_s, tck_fall_s, tdi_s, trst_low_s, resp_take_s, dmi_rw_s;
  logic [4:0]       ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DRW-1:0]   dr_sr_q, dr_sr_d, dr_shift_s;
  logic             tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic             req_valid_q, req_valid_d, outstanding_q, outstanding_d, discard_q, discard_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic [31:0]      req_data_q, req_data_d, last_rdata_q, last_rdata_d;
  logic [1:0]       req_op_q, req_op_d, dmistat_q, dmistat_d;

  // Two-flop synchronizers; tck keeps a third stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q <= 3'b000;
      tms_sync_q <= 2'b00;
      tdi_sync_q <= 2'b00;
    end else begin
      tck_sync_q <= {tck_sync_q[1:0], tck};
      tms_sync_q <= {tms_sync_q[0], tms};
      tdi_sync_q <= {tdi_sync_q[0], tdi};
    end
  end

`ifdef JTAG_TRST_EN
  logic [1:0] trst_sync_q;
  // trst synchronizer, idles high (inactive).
  always_ff @(posedge clk) begin
    if (rst) trst_sync_q <= 2'b11;
    else     trst_sync_q <= {trst_sync_q[0], trst};
  end
  assign trst_low_s = ~trst_sync_q[1];
`else
  assign trst_low_s = 1'b0;
`endif

  assign tck_rise_s  = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall_s  = ~tck_sync_q[1] & tck_sync_q[2];
  assign tdi_s       = tdi_sync_q[1];
  assign resp_take_s = dmi_resp_valid & outstanding_q & ~discard_q;
  assign dmi_rw_s    = (dr_sr_q[1:0] == 2'd1) || (dr_sr_q[1:0] == 2'd2);

  // TAP state register, stepped by synced tms on each tck rise.
  always_ff @(posedge clk) begin
    if (rst || trst_low_s) tap_q <= TLR;
    else if (tck_rise_s)   tap_q <= tap_next(tap_q, tms_sync_q[1]);
  end

  // Shift-right of the selected DR with tdi entering at that register's MSB.
  always_comb begin
    dr_shift_s = {1'b0, dr_sr_q[DRW-1:1]};
    case (ir_q)
      IR_IDC, IR_DTM: begin
        dr_shift_s[31]       = tdi_s;
        dr_shift_s[DRW-1:32] = '0;
      end
      IR_DMI:  dr_shift_s[DRW-1] = tdi_s;
      default: dr_shift_s = {{(DRW-1){1'b0}}, tdi_s};
    endcase
  end

  // Next state: DMI response handling first, then TAP capture/shift/update actions.
  always_comb begin
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    dr_sr_d       = dr_sr_q;
    tdo_d         = tdo_q;
    tdo_en_d      = tdo_en_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    req_op_d      = req_op_q;
    last_addr_d   = last_addr_q;
    discard_d     = discard_q & ~dmi_resp_valid;
    outstanding_d = outstanding_q & ~resp_take_s;
    last_rdata_d  = resp_take_s ? dmi_resp_data : last_rdata_q;
    dmistat_d     = (resp_take_s && dmistat_q == 2'd0 && dmi_resp_op[1]) ? dmi_resp_op : dmistat_q;
    req_valid_d   = req_valid_q & ~dmi_req_ready;
    if (tck_rise_s) begin
      case (tap_q)
        CAP_IR: ir_sr_d = 5'b00001;
        SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[4:1]};
        CAP_DR: begin
          case (ir_q)
            IR_IDC:  dr_sr_d = {{(DRW-32){1'b0}}, IDCODE};
            IR_DTM:  dr_sr_d = {{(DRW-32){1'b0}}, 14'd0, 2'b00, 1'b0, IDLE_HINT, dmistat_d, ABITS_F, 4'd1};
            IR_DMI: begin
              dr_sr_d   = {last_addr_q, last_rdata_d, (outstanding_d ? 2'd3 : dmistat_d)};
              dmistat_d = (outstanding_d && dmistat_d == 2'd0) ? 2'd3 : dmistat_d;
            end
            default: dr_sr_d = '0;
          endcase
        end
        SH_DR:   dr_sr_d = dr_shift_s;
        default: ;
      endcase
    end else if (tck_fall_s) begin
      tdo_d    = (tap_q == SH_IR) ? ir_sr_q[0] : dr_sr_q[0];
      tdo_en_d = (tap_q == SH_IR) || (tap_q == SH_DR);
      case (tap_q)
        UPD_IR: ir_d = ir_sr_q;
        UPD_DR: begin
          case (ir_q)
            IR_DTM: begin
              dmistat_d   = (dr_sr_q[16] || dr_sr_q[17]) ? 2'd0 : dmistat_d;
              req_valid_d = req_valid_d & ~dr_sr_q[17];
              // dmihardreset: forget the request and swallow its late response.
              if (dr_sr_q[17] && outstanding_d) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b1;
              end else begin
                discard_d = discard_d;
              end
            end
            IR_DMI: begin
              if (dmi_rw_s && dmistat_d == 2'd0 && outstanding_d) begin
                dmistat_d = 2'd3;
              end else if (dmi_rw_s && dmistat_d == 2'd0) begin
                req_valid_d   = 1'b1;
                req_addr_d    = dr_sr_q[DRW-1:34];
                req_data_d    = dr_sr_q[33:2];
                req_op_d      = dr_sr_q[1:0];
                last_addr_d   = dr_sr_q[DRW-1:34];
                outstanding_d = 1'b1;
              end else begin
                dmistat_d = dmistat_d;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end else begin
      tdo_d = tdo_q;
    end
    ir_d = (tap_q == TLR || trst_low_s) ? IR_IDC : ir_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q          <= IR_IDC;
      ir_sr_q       <= 5'd0;
      dr_sr_q       <= '0;
      tdo_q         <= 1'b0;
      tdo_en_q      <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= 32'd0;
      req_op_q      <= 2'd0;
      last_addr_q   <= '0;
      last_rdata_q  <= 32'd0;
      dmistat_q     <= 2'd0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      dr_sr_q       <= dr_sr_d;
      tdo_q         <= tdo_d;
      tdo_en_q      <= tdo_en_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      req_op_q      <= req_op_d;
      last_addr_q   <= last_addr_d;
      last_rdata_q  <= last_rdata_d;
      dmistat_q     <= dmistat_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign tdo           = tdo_q;
  assign tdo_en        = tdo_en_q;
  assign dmi_req_valid = req_valid_q;
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_data  = req_data_q;
  assign dmi_req_op    = req_op_q;

endmodule
